// File: rtl/riscv_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_stream_pkg
//  Description : Shared constants and helpers for the stream demultiplexer
//                slice: port count, select width, FSM state encoding and a
//                one-hot port decode helper.
//  Contents    : DEMUX_PORTS, SEL_W, sel_t, ST_IDLE, ST_IN_PKT, onehot_port()
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_stream_pkg;

    localparam int DEMUX_PORTS = 4;
    localparam int SEL_W       = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Packet-tracking FSM encoding (single bit, kept as plain constants so the
    // encoding is visible in waveforms and netlists).
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    // One-hot decode of a port index, gated by a valid qualifier so that an
    // empty buffer never presents a valid on any port.
    function automatic logic [DEMUX_PORTS-1:0] onehot_port(
        input logic en,
        input sel_t dst
    );
        logic [DEMUX_PORTS-1:0] vec;
        vec = '0;
        if (en) begin
            vec[dst] = 1'b1;
        end
        return vec;
    endfunction

endpackage : riscv_stream_pkg
`default_nettype wire

// File: rtl/stream_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : stream_reg_slice
//  Description : One-entry valid/ready register holding {data, last, dst}.
//                Full throughput: a new beat is accepted in the same cycle the
//                held beat drains. in_ready depends combinationally on
//                out_ready only.
//  Ports       : clk, rst_n            clock, async active-low reset
//                in_valid/in_ready     upstream handshake
//                in_data/in_last/in_dst upstream payload and route
//                out_valid/out_ready   downstream handshake (selected port)
//                out_data/out_last/out_dst held payload and route
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_reg_slice #(
    parameter int NrOfBits = 32,
    parameter int DstBits  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NrOfBits-1:0] in_data,
    input  logic                in_last,
    input  logic [DstBits-1:0]  in_dst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NrOfBits-1:0] out_data,
    output logic                out_last,
    output logic [DstBits-1:0]  out_dst
);

    logic buf_fire;
    logic accept;

    assign buf_fire = out_valid & out_ready;
    // Empty, or emptying this cycle: either way the entry can take a beat.
    assign in_ready = ~out_valid | buf_fire;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_dst   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_dst   <= in_dst;
        end else if (buf_fire) begin
            // Payload is left in place; only the valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule : stream_reg_slice
`default_nettype wire

// File: rtl/stream_demux_4.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_4
//  Description : Packet-aware 1-to-4 valid/ready demultiplexer. The destination
//                is taken from in_sel on the first beat of a packet and held
//                until the beat flagged last. One registered output stage:
//                1-cycle latency, 1 beat/cycle sustained.
//  Ports       : clk, rst_n               clock, async active-low reset
//                in_valid/in_ready        input handshake
//                in_data/in_last/in_sel   input payload, last flag, route
//                out_valid[3:0]           one-hot per-port valid
//                out_ready[3:0]           per-port ready
//                out_data/out_last        shared payload bus and last flag
//                busy                     packet open or beat buffered
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_4
    import riscv_stream_pkg::*;
#(
    parameter int NrOfBits = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NrOfBits-1:0]    in_data,
    input  logic                   in_last,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [DEMUX_PORTS-1:0] out_valid,
    input  logic [DEMUX_PORTS-1:0] out_ready,
    output logic [NrOfBits-1:0]    out_data,
    output logic                   out_last,
    output logic                   busy
);

    logic [0:0]  state;
    sel_t        dest;
    sel_t        route;
    logic        accept;
    logic        buf_valid;
    sel_t        buf_dst;
    logic        sel_ready;

    // Only the ready of the port currently holding the beat matters; the
    // other ready bits are intentionally ignored.
    assign sel_ready = out_ready[buf_dst];
    assign accept    = in_valid & in_ready;

    // First beat of a packet routes from in_sel; later beats use the latched
    // destination so in_sel may change freely mid-packet.
    assign route = (state == ST_IDLE) ? in_sel : dest;

    stream_reg_slice #(
        .NrOfBits (NrOfBits),
        .DstBits  (SEL_W)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_dst    (route),
        .out_valid (buf_valid),
        .out_ready (sel_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_dst   (buf_dst)
    );

    // Packet tracker: moves only on accepted beats. A single-beat packet
    // never leaves IDLE, so the next beat samples in_sel again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dest  <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!in_last) begin
                        state <= ST_IN_PKT;
                        dest  <= in_sel;
                    end
                end
                ST_IN_PKT: begin
                    if (in_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = onehot_port(buf_valid, buf_dst);
    assign busy      = (state == ST_IN_PKT) | buf_valid;

endmodule : stream_demux_4
`default_nettype wire

// File: tb/tb_stream_demux_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux_4
//  Description : Self-checking bench for stream_demux_4. Accepted input beats
//                are routed by a packet-level reference model into per-port
//                expected queues; a monitor pops and compares every output
//                handshake. Directed scenarios cover reset, destination hold,
//                back-to-back packets, backpressure and drain+fill; a random
//                valid/ready phase stresses ordering and packet integrity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_4;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int passed = 0;

    // Reference model state: expected {last,data} per port, packet tracking.
    logic [W:0] exp_q [4][$];
    bit         pkt_open;
    logic [1:0] pkt_dst;
    logic [1:0] mdst;
    logic [W:0] ebeat;

    stream_demux_4 #(.NrOfBits(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Monitor and reference model, sampled mid-cycle where everything is stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            pkt_open = 1'b0;
        end else begin
            if (out_valid != 4'b0000)
                check($countones(out_valid) == 1, "out_valid one-hot", out_valid, 1);
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check(1'b0, $sformatf("unexpected beat port%0d", k),
                              {out_last, out_data}, 0);
                    end else begin
                        ebeat = exp_q[k].pop_front();
                        check({out_last, out_data} == ebeat,
                              $sformatf("port%0d beat", k), {out_last, out_data}, ebeat);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (!pkt_open) mdst = in_sel;
                else           mdst = pkt_dst;
                if (!pkt_open && !in_last) begin
                    pkt_open = 1'b1;
                    pkt_dst  = in_sel;
                end else if (in_last) begin
                    pkt_open = 1'b0;
                end
                exp_q[mdst].push_back({in_last, in_data});
            end
        end
    end

    // Present a beat and hold it until accepted; returns at the edge+1 after
    // acceptance with in_valid dropped, so a following call is back-to-back.
    task automatic send(input logic [W-1:0] d, input logic l, input logic [1:0] s,
                        output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check(1'b0, "send timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        logic [3:0] ov;
        logic [3:0] qsz;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_sel = 2'd0; out_ready = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 4'b0000, "reset out_valid", out_valid, 0);
        check(out_data == '0, "reset out_data", out_data, 0);
        check(out_last == 1'b0, "reset out_last", out_last, 0);
        check(busy == 1'b0, "reset busy", busy, 0);
        check(in_ready == 1'b1, "reset in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-packet with the buffer full.
        out_ready = 4'b0000;
        send(32'hE0, 1'b0, 2'd1, w);
        check(busy == 1'b1, "mid-packet busy", busy, 1);
        check(out_valid == 4'b0010, "mid-packet out_valid", out_valid, 4'b0010);
        rst_n = 1'b0;
        #1;
        check(out_valid == 4'b0000, "async reset out_valid", out_valid, 0);
        check(busy == 1'b0, "async reset busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 4'b1111;
        @(posedge clk); #1;
        send(32'hE1, 1'b1, 2'd2, w);
        check(out_valid == 4'b0100, "post-reset route", out_valid, 4'b0100);
        check(out_data == 32'hE1, "post-reset data", out_data, 32'hE1);
        @(posedge clk); #1;

        // Destination held across the packet while in_sel changes.
        send(32'hA0, 1'b0, 2'd1, w);
        check(out_valid == 4'b0010 && out_data == 32'hA0 && !out_last, "pkt beat0",
              {out_valid, out_last, out_data}, {4'b0010, 1'b0, 32'hA0});
        send(32'hA1, 1'b0, 2'd3, w);
        check(out_valid == 4'b0010 && out_data == 32'hA1 && !out_last, "pkt beat1",
              {out_valid, out_last, out_data}, {4'b0010, 1'b0, 32'hA1});
        send(32'hA2, 1'b1, 2'd3, w);
        check(out_valid == 4'b0010 && out_data == 32'hA2 && out_last, "pkt beat2",
              {out_valid, out_last, out_data}, {4'b0010, 1'b1, 32'hA2});

        // Back-to-back single-beat packets to every port.
        for (int i = 0; i < 4; i++) begin
            send(32'hB0 + i, 1'b1, 2'(i), w);
            ov = 4'b0001 << i;
            check(w == 0, "b2b in_ready stall", w, 0);
            check(out_valid == ov, "b2b out_valid", out_valid, ov);
        end
        @(posedge clk); #1;

        // Backpressure on port 2 only.
        out_ready = 4'b1011;
        send(32'hC0, 1'b1, 2'd2, w);
        in_valid = 1'b1; in_data = 32'hC1; in_last = 1'b1; in_sel = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check(in_ready == 1'b0, "stall in_ready", in_ready, 0);
            check(out_data == 32'hC0 && out_valid == 4'b0100, "stall hold",
                  {out_valid, out_data}, {4'b0100, 32'hC0});
        end
        @(posedge clk); #1;
        out_ready = 4'b1111;
        send(32'hC1, 1'b1, 2'd2, w);
        check(w == 0, "release in_ready", w, 0);
        check(out_data == 32'hC1, "release data", out_data, 32'hC1);
        @(posedge clk); #1;

        // Simultaneous drain and fill.
        out_ready = 4'b0000;
        send(32'hD0, 1'b1, 2'd3, w);
        out_ready = 4'b1000;
        send(32'hD1, 1'b1, 2'd3, w);
        check(w == 0, "drain+fill in_ready", w, 0);
        check(out_data == 32'hD1 && out_valid == 4'b1000, "drain+fill replace",
              {out_valid, out_data}, {4'b1000, 32'hD1});
        out_ready = 4'b1111;
        @(posedge clk); #1;

        // Random valid/ready stress.
        for (int c = 0; c < 3000; c++) begin
            out_ready = 4'($urandom);
            in_valid  = ($urandom % 4) != 0;
            in_data   = $urandom;
            in_last   = ($urandom % 3) == 0;
            in_sel    = 2'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b1;
        out_ready = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) qsz[k] = (exp_q[k].size() != 0);
        check(qsz == 4'b0000, "drain queues empty", qsz, 0);
        check(out_valid == 4'b0000, "drain out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_stream_demux_4
`default_nettype wire
